// File: rtl/pwm_multichannel.sv
// Multi-channel PWM generator sharing one counter.
// Supports a programmable period, edge- or centre-aligned counting and
// per-channel polarity inversion. Every setting is copied into a shadow
// register only at a period boundary or on a synchronous restart, so a
// period already in progress is never disturbed by input changes.
module pwm_multichannel #(
    parameter int PWM_IN_SIZE = 10,
    parameter int NUM_CH      = 4
) (
    input  logic                          clk_in,
    input  logic                          reset_n_in,
    input  logic                          CE_in,
    input  logic                          synch_reset_in,
    input  logic                          mode_in,
    input  logic [PWM_IN_SIZE-1:0]        period_in,
    input  logic [NUM_CH*PWM_IN_SIZE-1:0] duty_in,
    input  logic [NUM_CH-1:0]             invert_in,
    output logic [NUM_CH-1:0]             PWM_out,
    output logic                          period_tick_out,
    output logic [PWM_IN_SIZE-1:0]        count_out
);

    localparam int W = PWM_IN_SIZE;
    localparam logic [W-1:0] ZERO = {W{1'b0}};
    localparam logic [W-1:0] ONE  = {{(W-1){1'b0}}, 1'b1};

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    // Live state
    logic [W-1:0]        count_q, count_d;
    dir_e                dir_q, dir_d;
    logic [NUM_CH-1:0]   pwm_q, pwm_d;
    logic                tick_q, tick_d;

    // Shadow copies of the settings used by the running period
    logic [W-1:0]        top_q, top_d;
    logic                mode_q, mode_d;
    logic [NUM_CH*W-1:0] duty_q, duty_d;
    logic [NUM_CH-1:0]   inv_q, inv_d;

    // Counter step results, valid when a CE tick occurs
    logic                centre_s;
    logic [W-1:0]        step_count_s;
    dir_e                step_dir_s;
    logic                boundary_s;
    logic [NUM_CH-1:0]   cmp_s;

    // Work out the next count, direction and whether this tick closes a period.
    // The >= / <= comparisons keep the counter self-recovering should it ever
    // hold a value outside the current range.
    always_comb begin
        centre_s     = mode_q & (top_q != ZERO);
        step_count_s = count_q;
        step_dir_s   = dir_q;
        boundary_s   = 1'b0;
        if (!centre_s) begin
            step_dir_s = DIR_UP;
            if (count_q >= top_q) begin
                boundary_s   = 1'b1;
                step_count_s = ZERO;
            end else begin
                step_count_s = count_q + ONE;
            end
        end else begin
            case (dir_q)
                DIR_UP: begin
                    if (count_q >= top_q) begin
                        step_count_s = top_q - ONE;
                        // With TOP=1 the downward slope is empty: turning at the top is the boundary.
                        if (top_q == ONE) begin
                            boundary_s = 1'b1;
                            step_dir_s = DIR_UP;
                        end else begin
                            step_dir_s = DIR_DOWN;
                        end
                    end else begin
                        step_count_s = count_q + ONE;
                    end
                end
                DIR_DOWN: begin
                    if (count_q <= ONE) begin
                        boundary_s   = 1'b1;
                        step_count_s = ZERO;
                        step_dir_s   = DIR_UP;
                    end else begin
                        step_count_s = count_q - ONE;
                    end
                end
                default: begin
                    boundary_s   = 1'b1;
                    step_count_s = ZERO;
                    step_dir_s   = DIR_UP;
                end
            endcase
        end
    end

    // Per-channel duty compare against the pre-update count, then polarity
    always_comb begin
        cmp_s = {NUM_CH{1'b0}};
        for (int i = 0; i < NUM_CH; i++) begin
            cmp_s[i] = (count_q < duty_q[i*W +: W]) ^ inv_q[i];
        end
    end

    // Next-state selection: restart beats count enable; idle cycles hold state
    always_comb begin
        count_d = count_q;
        dir_d   = dir_q;
        pwm_d   = pwm_q;
        tick_d  = 1'b0;
        top_d   = top_q;
        mode_d  = mode_q;
        duty_d  = duty_q;
        inv_d   = inv_q;
        if (synch_reset_in) begin
            count_d = ZERO;
            dir_d   = DIR_UP;
            pwm_d   = {NUM_CH{1'b0}};
            tick_d  = 1'b0;
            top_d   = period_in;
            mode_d  = mode_in;
            duty_d  = duty_in;
            inv_d   = invert_in;
        end else if (CE_in) begin
            count_d = step_count_s;
            dir_d   = step_dir_s;
            pwm_d   = cmp_s;
            tick_d  = boundary_s;
            if (boundary_s) begin
                top_d  = period_in;
                mode_d = mode_in;
                duty_d = duty_in;
                inv_d  = invert_in;
            end else begin
                top_d  = top_q;
                mode_d = mode_q;
                duty_d = duty_q;
                inv_d  = inv_q;
            end
        end else begin
            tick_d = 1'b0;
        end
    end

    // State registers with asynchronous clear
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            count_q <= ZERO;
            dir_q   <= DIR_UP;
            pwm_q   <= {NUM_CH{1'b0}};
            tick_q  <= 1'b0;
            top_q   <= ZERO;
            mode_q  <= 1'b0;
            duty_q  <= {(NUM_CH*W){1'b0}};
            inv_q   <= {NUM_CH{1'b0}};
        end else begin
            count_q <= count_d;
            dir_q   <= dir_d;
            pwm_q   <= pwm_d;
            tick_q  <= tick_d;
            top_q   <= top_d;
            mode_q  <= mode_d;
            duty_q  <= duty_d;
            inv_q   <= inv_d;
        end
    end

    assign PWM_out         = pwm_q;
    assign period_tick_out = tick_q;
    assign count_out       = count_q;

endmodule
